// File: rtl/pipe_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pipe_ctrl                                                |
// | Description : Pipeline control for the 5-stage MIPS core. Merges stage |
// |               stall requests, sequences exception/ERET flushes (held   |
// |               off while a data-bus transaction is in flight), supplies |
// |               the redirect PC, and keeps a stall watchdog and a stall  |
// |               cycle counter.                                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        bus_busy_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o,
  output logic [31:0] stall_cycles_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int unsigned WD_W = $clog2(STALL_TIMEOUT);
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(STALL_TIMEOUT - 1);
  localparam logic [5:0] STALL_ALL = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_BUS = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [31:0]       exc_q, exc_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       cycles_q, cycles_d;

  logic [5:0]        stall_vec;
  logic              flush_now;
  logic              flush_start;
  logic [31:0]       redirect_pc;

  // Next-state, flush sequencing and combinational stall/flush outputs.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    exc_d       = exc_q;
    epc_d       = epc_q;
    new_pc_d    = new_pc_q;
    stall_vec   = 6'b000000;
    flush_now   = 1'b0;
    flush_start = 1'b0;
    redirect_pc = new_pc_q;

    unique case (state_q)
      ST_RUN: begin
        if (excepttype_i != 32'd0) begin
          if (bus_busy_i) begin
            // Bus cannot be aborted: freeze the pipe and remember the first exception.
            stall_vec = STALL_ALL;
            exc_d     = excepttype_i;
            epc_d     = cp0_epc_i;
            state_d   = ST_WAIT_BUS;
          end else begin
            flush_start = 1'b1;
            redirect_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
          end
        end else if (stallreq_mem_i) begin
          stall_vec = 6'b011111;
        end else if (stallreq_ex_i) begin
          stall_vec = 6'b001111;
        end else if (stallreq_id_i) begin
          stall_vec = 6'b000111;
        end else if (stallreq_if_i) begin
          stall_vec = 6'b000011;
        end
      end
      ST_WAIT_BUS: begin
        if (bus_busy_i) begin
          stall_vec = STALL_ALL;
        end else begin
          flush_start = 1'b1;
          redirect_pc = (exc_q == ERET_CODE) ? epc_q : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        flush_now = 1'b1;
        fcnt_d    = fcnt_q - FC_ONE;
        if (fcnt_q == FC_ONE) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (flush_start) begin
      flush_now = 1'b1;
      new_pc_d  = redirect_pc;
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        fcnt_d  = FC_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end

    // Reset dominates the outputs even in the cycle it is sampled.
    if (rst) begin
      stall_vec   = 6'b000000;
      flush_now   = 1'b0;
      redirect_pc = 32'd0;
    end
  end

  // Watchdog and stall-cycle counters, both saturating.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    if (stall_vec != 6'b000000) begin
      if (wd_q == WD_MAX) begin
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      if (cycles_q != 32'hffff_ffff) begin
        cycles_d = cycles_q + 32'd1;
      end
    end else begin
      wd_d = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      exc_q     <= 32'd0;
      epc_q     <= 32'd0;
      new_pc_q  <= 32'd0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      exc_q     <= exc_d;
      epc_q     <= epc_d;
      new_pc_q  <= new_pc_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stall_o         = stall_vec;
  assign flush_o         = flush_now;
  assign new_pc_o        = redirect_pc;
  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = cycles_q;

endmodule
`default_nettype wire
